dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge_if.sv | 20 ++
 rtl/dmem_bridge.sv | 158 +++++++++++++++
 tb/tb_dmem_bridge.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// Word-addressed request/acknowledge bus between dmem_bridge (master) and the data memory (slave).
interface dmem_bridge_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: lane steering, load extension and pipeline stall control.
// Define DMEM_BRIDGE_STORE_BUFFER_EN to post stores through a one-entry buffer without stalling.
module dmem_bridge (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [2:0]    dmem_SEL,
  input  logic          dmem_WE,
  input  logic          dmem_RE,
  output logic [31:0]   rdata,
  output logic          stall_req,
  output logic          misalign_err,
  dmem_bridge_if.master mem
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  state_t state_reg, state_next;

  logic        mem_req_reg, mem_we_reg;
  logic [29:0] mem_addr_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg, rdata_reg;
  logic [1:0]  lane_reg;
  logic [2:0]  sel_reg;

  logic        is_half, is_byte, access, misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, load_ext;
  logic [15:0] lane_data;
  logic        issue, post_store, complete, drain_done, stall_raw, misalign_raw;
  logic        buffer_full, buffer_allowed;

  // Reserved size encodings fall through to word handling.
  assign is_half    = (dmem_SEL[1:0] == 2'b01);
  assign is_byte    = (dmem_SEL[1:0] == 2'b10);
  assign access     = dmem_WE | dmem_RE;
  assign misaligned = is_byte ? 1'b0 : (is_half ? addr[0] : (addr[1:0] != 2'b00));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    if (is_byte) begin
      be_next    = 4'b0001 << addr[1:0];
      wdata_next = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_next    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    lane_data = 16'(mem.mem_rdata >> {lane_reg, 3'b000});
    case (sel_reg[1:0])
      2'b10:   load_ext = {{24{sel_reg[2] & lane_data[7]}},  lane_data[7:0]};
      2'b01:   load_ext = {{16{sel_reg[2] & lane_data[15]}}, lane_data[15:0]};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    stall_raw    = 1'b0;
    misalign_raw = 1'b0;
    issue        = 1'b0;
    post_store   = 1'b0;
    complete     = 1'b0;
    drain_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        // A posted store drains while the FSM itself stays in IDLE.
        drain_done = buffer_full & mem.mem_ack;
        if (access) begin
          if (misaligned) begin
            misalign_raw = 1'b1;
          end else if (buffer_full) begin
            stall_raw = 1'b1;
          end else if (dmem_WE & buffer_allowed) begin
            post_store = 1'b1;
          end else begin
            stall_raw  = 1'b1;
            issue      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (mem.mem_ack) begin
          complete   = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated so the combinational outputs read zero for the whole reset interval.
  assign stall_req    = stall_raw & ~reset;
  assign misalign_err = misalign_raw & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 30'd0;
      mem_be_reg    <= 4'd0;
      mem_wdata_reg <= 32'd0;
      rdata_reg     <= 32'd0;
      lane_reg      <= 2'd0;
      sel_reg       <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (issue | post_store) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= dmem_WE;
        mem_addr_reg  <= addr[31:2];
        mem_be_reg    <= be_next;
        mem_wdata_reg <= wdata_next;
        lane_reg      <= addr[1:0];
        sel_reg       <= dmem_SEL;
      end else if (complete | drain_done) begin
        mem_req_reg <= 1'b0;
      end
      if (complete & ~mem_we_reg) begin
        rdata_reg <= load_ext;
      end
    end
  end

`ifdef DMEM_BRIDGE_STORE_BUFFER_EN
  logic sb_full_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_full_reg <= 1'b0;
    end else if (post_store) begin
      sb_full_reg <= 1'b1;
    end else if (drain_done) begin
      sb_full_reg <= 1'b0;
    end
  end

  assign buffer_full    = sb_full_reg;
  assign buffer_allowed = 1'b1;
`else
  assign buffer_full    = 1'b0;
  assign buffer_allowed = 1'b0;
`endif

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_be    = mem_be_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign rdata         = rdata_reg;
endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: byte-addressed reference memory, latency-programmable slave,
// decoupled monitor checking bus requests, load results and misalignment pulses.
`timescale 1ns/1ps
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  dmem_SEL = '0;
  logic        dmem_WE = 1'b0;
  logic        dmem_RE = 1'b0;
  logic [31:0] rdata;
  logic        stall_req, misalign_err;

  dmem_bridge_if bus ();

  dmem_bridge dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .dmem_SEL(dmem_SEL),
    .dmem_WE(dmem_WE), .dmem_RE(dmem_RE), .rdata(rdata), .stall_req(stall_req),
    .misalign_err(misalign_err), .mem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  req_t        req_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] mis_q[$];
  logic [7:0]  ref_mem [0:63];
  logic [31:0] slave_mem [0:15];
  int          lat_cfg = 1;
  bit          slave_en = 1'b1;
  logic        manual_ack = 1'b0;
  int          txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] sel);
    case (sel[1:0])
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sel);
    int          sz = size_of(sel);
    logic [31:0] v = '0;
    for (int i = 0; i < sz; i++) v |= 32'(ref_mem[6'(a + i)]) << (8 * i);
    if (sel[2] && sz < 4 && v[8*sz-1]) v |= ~((32'h1 << (8 * sz)) - 1);
    return v;
  endfunction

  task automatic preset_word(input logic [31:0] a, input logic [31:0] v);
    slave_mem[a[5:2]] = v;
    for (int i = 0; i < 4; i++) ref_mem[6'(a + i)] = v[8*i +: 8];
  endtask

  // One M-stage instruction: push expectations, present it, hold until the pipeline retires it.
  task automatic do_access(input logic we, input logic re, input logic [2:0] sel,
                           input logic [31:0] a, input logic [31:0] d, input int lat,
                           input bit chk_stall, output int stalls);
    int   sz = size_of(sel);
    bit   acc = we | re;
    bit   mis = acc && ((a % sz) != 0);
    int   m;
    req_t r;
    if (acc && !mis) begin
      m       = ((1 << sz) - 1) << (a & 3);
      r.we    = we;
      r.waddr = a[31:2];
      r.be    = m[3:0];
      for (int i = 0; i < 4; i++) r.wd[8*i +: 8] = d[8*(i % sz) +: 8];
      req_q.push_back(r);
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[6'(a + i)] = d[8*i +: 8];
      end else begin
        ld_q.push_back(model_load(a, sel));
      end
    end
    if (mis) mis_q.push_back(a);
    lat_cfg = lat;
    addr = a; wdata = d; dmem_SEL = sel; dmem_WE = we; dmem_RE = re;
    stalls = 0;
    @(negedge clk);
    while (stall_req && stalls < 60) begin
      stalls++;
      @(negedge clk);
    end
    if (stall_req) check("retire timeout", 32'(stall_req), 32'd0);
    if (chk_stall) check("stall cycles", stalls, (acc && !mis) ? 1 + lat : 0);
    txn++;
    $display("txn %0d: we=%0b re=%0b sel=%b addr=%h wdata=%h lat=%0d stalls=%0d",
             txn, we, re, sel, a, d, lat, stalls);
    @(posedge clk); #1;
    dmem_WE = 1'b0; dmem_RE = 1'b0;
  endtask

  // Memory slave: acks after lat_cfg cycles of mem_req, applies byte enables on stores.
  initial begin : slave
    int wait_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!slave_en) begin
        bus.mem_ack = manual_ack;
        wait_cnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        wait_cnt++;
        if (wait_cnt >= lat_cfg) begin
          wait_cnt = 0;
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[i]) slave_mem[bus.mem_addr[3:0]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
          end else begin
            bus.mem_rdata = slave_mem[bus.mem_addr[3:0]];
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    bit          prev_req = 1'b0;
    bit          load_done = 1'b0;
    bit          cur_valid = 1'b0;
    req_t        cur;
    logic [31:0] exp_rd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0; load_done = 1'b0; cur_valid = 1'b0; exp_rd = '0;
      end else begin
        if (load_done) begin
          load_done = 1'b0;
          if (ld_q.size() == 0) check("unexpected load completion", 32'd1, 32'd0);
          else exp_rd = ld_q.pop_front();
        end
        check("rdata", rdata, exp_rd);
        if (bus.mem_req && !prev_req) begin
          cur_valid = (req_q.size() != 0);
          if (cur_valid) cur = req_q.pop_front();
          else check("unexpected mem_req", 32'd1, 32'd0);
        end
        if (bus.mem_req && cur_valid) begin
          check("mem_we", 32'(bus.mem_we), 32'(cur.we));
          check("mem_addr", 32'(bus.mem_addr), 32'(cur.waddr));
          check("mem_be", 32'(bus.mem_be), 32'(cur.be));
          check("mem_wdata", bus.mem_wdata, cur.wd);
        end
        if (bus.mem_req && bus.mem_ack && !bus.mem_we) load_done = 1'b1;
        if (misalign_err) begin
          if (mis_q.size() == 0) check("unexpected misalign_err", 32'd1, 32'd0);
          else check("misalign addr", addr, mis_q.pop_front());
        end
        prev_req = bus.mem_req;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int          st;
    logic [31:0] r, a, d;
    logic [2:0]  sel;
    logic        we, re;
    for (int w = 0; w < 16; w++) preset_word(32'(w * 4), $urandom());

    // Reset with an aligned load presented: every output must stay zero.
    dmem_RE = 1'b1; addr = 32'h100; dmem_SEL = 3'b000;
    repeat (2) @(negedge clk);
    check("rst stall_req", 32'(stall_req), 32'd0);
    check("rst misalign_err", 32'(misalign_err), 32'd0);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst mem_be", 32'(bus.mem_be), 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    check("rst rdata", rdata, 32'd0);
    dmem_RE = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    // Reset during the second BUSY cycle, followed by a stale ack.
    begin
      req_t rr;
      rr.we = 1'b0; rr.waddr = 30'h40; rr.be = 4'hF; rr.wd = 32'h0;
      req_q.push_back(rr);
      slave_en = 1'b0; manual_ack = 1'b0;
      addr = 32'h100; wdata = '0; dmem_SEL = 3'b000; dmem_RE = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("abort mem_req drop", 32'(bus.mem_req), 32'd0);
      check("abort stall_req", 32'(stall_req), 32'd0);
      dmem_RE = 1'b0;
      @(posedge clk); #2 reset = 1'b0;
      manual_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stale ack mem_req", 32'(bus.mem_req), 32'd0);
      check("stale ack mem_addr", 32'(bus.mem_addr), 32'd0);
      check("stale ack mem_be", 32'(bus.mem_be), 32'd0);
      check("stale ack stall_req", 32'(stall_req), 32'd0);
      check("stale ack rdata", rdata, 32'd0);
      @(posedge clk); #1;
      manual_ack = 1'b0;
      @(negedge clk);
      check("post-abort mem_req", 32'(bus.mem_req), 32'd0);
      slave_en = 1'b1;
      @(posedge clk); #1;
    end

    // Directed scenarios.
    preset_word(32'h100, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 3'b000, 32'h100, 32'h0, 3, 1'b1, st);
    check("lw stall count", st, 32'd4);
    check("lw rdata", rdata, 32'hDEADBEEF);

    preset_word(32'h100, 32'h80112233);
    do_access(1'b0, 1'b1, 3'b110, 32'h103, 32'h0, 1, 1'b1, st);
    check("lb rdata", rdata, 32'hFFFFFF80);
    check("lb stall count", st, 32'd2);
    do_access(1'b0, 1'b1, 3'b010, 32'h103, 32'h0, 2, 1'b1, st);
    check("lbu rdata", rdata, 32'h00000080);

`ifdef DMEM_BRIDGE_STORE_BUFFER_EN
    do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0000ABCD, 2, 1'b0, st);
    check("sh posted stall", st, 32'd0);
`else
    do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0000ABCD, 2, 1'b1, st);
    check("sh stall count", st, 32'd3);
`endif

    do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0, 1, 1'b1, st);
    check("misaligned lw stall", st, 32'd0);
    do_access(1'b0, 1'b1, 3'b101, 32'h203, 32'h0, 1, 1'b1, st);
    do_access(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1, 1'b1, st);

`ifdef DMEM_BRIDGE_STORE_BUFFER_EN
    do_access(1'b1, 1'b0, 3'b000, 32'h300, 32'h12345678, 2, 1'b0, st);
    check("buffered sw stall", st, 32'd0);
    do_access(1'b0, 1'b1, 3'b000, 32'h300, 32'h0, 2, 1'b0, st);
    check("lw behind sw stall", st, 32'd5);
    check("lw behind sw rdata", rdata, 32'h12345678);
`endif

    // Randomized mix of sizes, extensions, alignments, latencies and idle slots.
    for (int n = 0; n < 200; n++) begin
      r   = $urandom();
      a   = $urandom();
      d   = $urandom();
      sel = r[2:0];
      we  = r[3];
      re  = r[4] | (r[7:5] == 3'b000);
      if (r[9:8] == 2'b00) a = {a[31:6], a[0], a[1], 4'b0000};
`ifdef DMEM_BRIDGE_STORE_BUFFER_EN
      do_access(we, re, sel, a, d, int'($urandom_range(1, 4)), 1'b0, st);
`else
      do_access(we, re, sel, a, d, int'($urandom_range(1, 4)), 1'b1, st);
`endif
    end

    repeat (12) @(posedge clk);
    #1;
    check("pending requests", req_q.size(), 32'd0);
    check("pending loads", ld_q.size(), 32'd0);
    check("pending misaligns", mis_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
